// File: rtl/bfloat16_adder_feeder.sv
// Purpose : feeds queued bfloat16 operand pairs to a free-running bfloat16_adder, captures real sums.
// Latency : pair issues at the next adder_ready after it is queued; its sum is on res_sum one
//           cycle after the following adder_ready.
// Backpressure: in_ready=!queue_full; issue stalls (dummy 0+0 op) while the result buffer could overflow.
//
// Ports:
//   clock, nreset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/b operand-pair input (valid/ready)
//   adder_ready, adder_sum   adder handshake: previous op done, sum valid this cycle
//   adder_a, adder_b         registered operands presented to the adder
//   res_valid/res_ready/res_sum  2-entry result buffer head (valid/ready)
//   timeout_err              sticky watchdog flag
//
// Optional feature: define BF16_FEEDER_TIMEOUT_EN to enable the adder_ready watchdog
// (TIMEOUT cycles). Without it timeout_err is tied low and no counter exists.
module bfloat16_adder_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        adder_ready,
    input  logic [15:0] adder_sum,
    output logic [15:0] adder_a,
    output logic [15:0] adder_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_sum,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time parameter sanity.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bfloat16_adder_feeder: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("bfloat16_adder_feeder: TIMEOUT must be >= 2");
    end

    // ---------------- operand queue ----------------
    logic [15:0]   q_a_q [DEPTH];
    logic [15:0]   q_b_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // ---------------- adder side ----------------
    logic [15:0] adder_a_q, adder_b_q;
    logic        inflight_q;
    logic        abandon;

    // ---------------- result buffer ----------------
    logic [15:0] r_mem_q [2];
    logic        r_wr_q, r_rd_q;
    logic [1:0]  r_occ_q, occ_next;

    logic push, issue, capture, drain;

    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign push      = in_valid && in_ready;

    assign res_valid = (r_occ_q != 2'd0);
    assign res_sum   = r_mem_q[r_rd_q];
    assign drain     = res_valid && res_ready;

    // A real op completes only at adder_ready; dummy ops (inflight=0) are discarded.
    assign capture   = adder_ready && inflight_q;
    assign occ_next  = r_occ_q + 2'(capture) - 2'(drain);

    // Issue only if the result it will produce is guaranteed a slot: the buffer never
    // refuses adder output, so space is reserved before the op starts.
    assign issue     = adder_ready && (cnt_q != '0) && (occ_next < 2'd2);

    assign cnt_d     = cnt_q + CW'(push) - CW'(issue);

    assign adder_a   = adder_a_q;
    assign adder_b   = adder_b_q;

    // Queue storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (push) begin
            q_a_q[wr_ptr_q] <= in_a;
            q_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            adder_a_q  <= 16'h0000;
            adder_b_q  <= 16'h0000;
            inflight_q <= 1'b0;
            r_mem_q[0] <= 16'h0000;
            r_mem_q[1] <= 16'h0000;
            r_wr_q     <= 1'b0;
            r_rd_q     <= 1'b0;
            r_occ_q    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;

            // Operands change only at the adder's op boundary; an idle slot runs 0+0.
            if (adder_ready) begin
                adder_a_q  <= issue ? q_a_q[rd_ptr_q] : 16'h0000;
                adder_b_q  <= issue ? q_b_q[rd_ptr_q] : 16'h0000;
                inflight_q <= issue;
            end else if (abandon) begin
                inflight_q <= 1'b0;
            end

            if (capture) begin
                r_mem_q[r_wr_q] <= adder_sum;
                r_wr_q          <= ~r_wr_q;
            end
            if (drain) begin
                r_rd_q <= ~r_rd_q;
            end
            r_occ_q <= occ_next;
        end
    end

`ifdef BF16_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          err_q;

    // Counts cycles since the last adder_ready, saturating at TIMEOUT. The op is
    // abandoned on the edge where the count would reach TIMEOUT.
    assign timer_d = adder_ready                  ? '0 :
                     (timer_q == TW'(TIMEOUT))    ? timer_q :
                                                    timer_q + TW'(1);
    assign abandon = !adder_ready && inflight_q && (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            if (abandon) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    assign abandon     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bfloat16_adder_feeder.sv
// Purpose : directed self-checking bench for bfloat16_adder_feeder with a lookup-table adder model.
// Latency : adder model pulses adder_ready every 3 cycles when called; sums come from a fixed table.
// Backpressure: bench toggles res_ready and holds in_valid against a full queue.
module tb_bfloat16_adder_feeder;

    logic        clock = 1'b0;
    logic        nreset;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        adder_ready;
    logic [15:0] adder_sum;
    logic [15:0] adder_a, adder_b;
    logic        res_valid, res_ready;
    logic [15:0] res_sum;
    logic        timeout_err;

    int          n_chk = 0;
    int          n_err = 0;

    // Adder model state: operands it sampled for the op currently in progress.
    logic [15:0] op_a = 16'h0000;
    logic [15:0] op_b = 16'h0000;
    logic [15:0] got [$];

    always #5 clock = ~clock;

    bfloat16_adder_feeder #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .adder_ready (adder_ready),
        .adder_sum   (adder_sum),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .timeout_err (timeout_err)
    );

    // Record every result handed to the consumer (sampled after inputs settle).
    always @(negedge clock) begin
        #2;
        if (nreset === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1)
            got.push_back(res_sum);
    end

    // Hand-computed bfloat16 sums for the operand pairs used here.
    function automatic logic [15:0] bf16_sum(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {16'h0000, 16'h0000}: return 16'h0000; // 0+0
            {16'h3F80, 16'h4000}: return 16'h4040; // 1+2=3
            {16'h3F80, 16'h3F80}: return 16'h4000; // 1+1=2
            {16'h4000, 16'h4000}: return 16'h4080; // 2+2=4
            {16'h4040, 16'h4040}: return 16'h40C0; // 3+3=6
            {16'h4080, 16'h3F80}: return 16'h40A0; // 4+1=5
            {16'h40C0, 16'h3F80}: return 16'h40E0; // 6+1=7
            default:              return 16'hDEAD;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_got(input int idx, input logic [15:0] exp);
        logic [15:0] v;
        v = (idx < got.size()) ? got[idx] : 16'hBAD0;
        check($sformatf("result[%0d]", idx), v, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One adder op boundary: ready pulse carrying the previous op's sum, then the
    // adder samples a, then b. Called and returns at a negedge.
    task automatic pulse();
        adder_ready = 1'b1;
        adder_sum   = bf16_sum(op_a, op_b);
        @(negedge clock);
        adder_ready = 1'b0;
        adder_sum   = 16'h0000;
        op_a        = adder_a;
        @(negedge clock);
        op_b        = adder_b;
        @(negedge clock);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        k        = 0;
        while (!in_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!in_ready) check("push_wait_in_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        nreset      = 1'b1;
        in_valid    = 1'b0;
        in_a        = 16'h0000;
        in_b        = 16'h0000;
        adder_ready = 1'b0;
        adder_sum   = 16'h0000;
        res_ready   = 1'b0;
        #1 nreset   = 1'b0;

        // 1. reset state and first adder_ready yields nothing
        tick(3);
        check("rst_in_ready",  {15'd0, in_ready},    16'd1);
        check("rst_res_valid", {15'd0, res_valid},   16'd0);
        check("rst_res_sum",   res_sum,              16'h0000);
        check("rst_adder_a",   adder_a,              16'h0000);
        check("rst_adder_b",   adder_b,              16'h0000);
        check("rst_timeout",   {15'd0, timeout_err}, 16'd0);
        nreset = 1'b1;
        tick(1);
        pulse();
        check("first_rdy_no_result", {15'd0, res_valid}, 16'd0);
        check("first_rdy_dummy_a",   adder_a,            16'h0000);

        // 2. single pair latency
        got.delete();
        push(16'h3F80, 16'h4000);
        check("t2_pre_valid", {15'd0, res_valid}, 16'd0);
        pulse();
        check("t2_adder_a", adder_a, 16'h3F80);
        check("t2_adder_b", adder_b, 16'h4000);
        check("t2_not_yet", {15'd0, res_valid}, 16'd0);
        pulse();
        check("t2_res_valid", {15'd0, res_valid}, 16'd1);
        check("t2_res_sum",   res_sum,            16'h4040);
        check("t2_dummy_a",   adder_a,            16'h0000);
        res_ready = 1'b1;
        tick(1);
        check("t2_drained", {15'd0, res_valid}, 16'd0);
        check("t2_count",   16'(got.size()),    16'd1);
        check_got(0, 16'h4040);

        // 3. fill queue, fifth pair held until an issue frees a slot
        got.delete();
        push(16'h3F80, 16'h3F80);
        push(16'h4000, 16'h4000);
        push(16'h4040, 16'h4040);
        push(16'h4080, 16'h3F80);
        check("t3_full", {15'd0, in_ready}, 16'd0);
        in_valid = 1'b1;
        in_a     = 16'h40C0;
        in_b     = 16'h3F80;
        tick(3);
        check("t3_still_full", {15'd0, in_ready}, 16'd0);
        pulse();
        check("t3_fifth_taken", {15'd0, in_ready}, 16'd0);
        in_valid = 1'b0;
        repeat (6) pulse();
        check("t3_count", 16'(got.size()), 16'd5);
        check_got(0, 16'h4000);
        check_got(1, 16'h4080);
        check_got(2, 16'h40C0);
        check_got(3, 16'h40A0);
        check_got(4, 16'h40E0);

        // 4. consumer stalled: two results buffered, then dummies
        got.delete();
        res_ready = 1'b0;
        push(16'h3F80, 16'h3F80);
        push(16'h4000, 16'h4000);
        push(16'h4040, 16'h4040);
        push(16'h4080, 16'h3F80);
        repeat (3) pulse();
        check("t4_dummy_a",   adder_a,            16'h0000);
        check("t4_res_valid", {15'd0, res_valid}, 16'd1);
        check("t4_head",      res_sum,            16'h4000);
        pulse();
        check("t4_dummy_a2",  adder_a,            16'h0000);
        check("t4_head_hold", res_sum,            16'h4000);
        check("t4_none_out",  16'(got.size()),    16'd0);
        res_ready = 1'b1;
        repeat (4) pulse();
        check("t4_count", 16'(got.size()), 16'd4);
        check_got(0, 16'h4000);
        check_got(1, 16'h4080);
        check_got(2, 16'h40C0);
        check_got(3, 16'h40A0);

        // 5. reset while an op is in flight
        got.delete();
        push(16'h4000, 16'h4000);
        pulse();
        check("t5_issued", adder_a, 16'h4000);
        nreset = 1'b0;
        tick(1);
        check("t5_in_ready",  {15'd0, in_ready},  16'd1);
        check("t5_res_valid", {15'd0, res_valid}, 16'd0);
        check("t5_adder_a",   adder_a,            16'h0000);
        check("t5_adder_b",   adder_b,            16'h0000);
        check("t5_res_sum",   res_sum,            16'h0000);
        nreset = 1'b1;
        tick(1);
        pulse();
        pulse();
        check("t5_no_stale",  16'(got.size()),    16'd0);
        check("t5_res_valid2", {15'd0, res_valid}, 16'd0);

`ifdef BF16_FEEDER_TIMEOUT_EN
        // 6. watchdog abandons the in-flight op, keeps the queue
        got.delete();
        push(16'h3F80, 16'h4000);
        push(16'h4000, 16'h4000);
        push(16'h4080, 16'h3F80);
        pulse();
        check("t6_issued", adder_a, 16'h3F80);
        tick(55);
        check("t6_no_err_yet", {15'd0, timeout_err}, 16'd0);
        tick(10);
        check("t6_err", {15'd0, timeout_err}, 16'd1);
        repeat (3) pulse();
        check("t6_count", 16'(got.size()), 16'd2);
        check_got(0, 16'h4080);
        check_got(1, 16'h40A0);
        check("t6_sticky", {15'd0, timeout_err}, 16'd1);
`else
        tick(70);
        check("t6_err_tied", {15'd0, timeout_err}, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
